// File: rtl/cube_pkg.sv
// Shared types and helpers for the LED cube face scan controller.
package cube_pkg;

  localparam int N_ROWS = 10;
  localparam int ROW_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DRIVE
  } state_e;

  typedef logic [3:0] row_idx_t;

  localparam logic [ROW_W-1:0] ROW0_SEL = {1'b1, {(ROW_W-1){1'b0}}};

  // Row r drives bit (9-r); out-of-range rows select nothing.
  function automatic logic [ROW_W-1:0] row_onehot(input row_idx_t r);
    return ROW0_SEL >> r;
  endfunction

endpackage

// File: rtl/cube_row_buffer.sv
// Double-buffered 10x10 frame store: bank_sel picks the displayed (front) bank,
// writes always land in the other (back) bank.
module cube_row_buffer
  import cube_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        bank_sel,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [9:0]  wr_data,
  input  logic [3:0]  rd_row,
  output logic [9:0]  rd_data
);

  logic [ROW_W-1:0] mem_q [2][N_ROWS];
  logic [ROW_W-1:0] mem_d [2][N_ROWS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en && (wr_addr < 4'(N_ROWS))) begin
      mem_d[~bank_sel][wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = (rd_row < 4'(N_ROWS)) ? mem_q[bank_sel][rd_row] : '0;

endmodule

// File: rtl/cube_frame_sequencer.sv
// Row-multiplexed scan of a double-buffered 10x10 frame with blanking between
// rows; buffer swaps are deferred to the frame boundary so frames never tear.
module cube_frame_sequencer
  import cube_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [9:0] wr_data,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       frame_start,
  output logic [9:0] x,
  output logic [9:0] y
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam row_idx_t         LAST_ROW   = row_idx_t'(N_ROWS - 1);

  state_e           state_q, state_d;
  row_idx_t         row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bank_q, bank_d;
  logic             pend_q, pend_d;
  logic [ROW_W-1:0] x_q, x_d, y_q, y_d;
  logic             ack_q, ack_d, fs_q, fs_d;
  logic [ROW_W-1:0] front_row;
  logic             boundary;
  logic             do_swap;

  cube_row_buffer u_buf (
    .clk      (clk),
    .rst      (rst),
    .bank_sel (bank_q),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_row   (row_q),
    .rd_data  (front_row)
  );

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    x_d      = '0;
    y_d      = '0;
    fs_d     = 1'b0;
    boundary = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      row_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          row_d   = '0;
          cnt_d   = '0;
          fs_d    = 1'b1;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
            x_d     = front_row;
            y_d     = row_onehot(row_q);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (row_q == LAST_ROW) begin
              row_d    = '0;
              boundary = 1'b1;
              fs_d     = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            x_d   = front_row;
            y_d   = row_onehot(row_q);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // A request arriving on the boundary cycle itself is honoured immediately.
    do_swap = boundary && (pend_q || swap_req);
    ack_d   = do_swap;
    bank_d  = bank_q ^ do_swap;
    pend_d  = boundary ? 1'b0 : (pend_q || swap_req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      bank_q  <= 1'b0;
      pend_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ack_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      pend_q  <= pend_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ack_q   <= ack_d;
      fs_q    <= fs_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign swap_ack    = ack_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_cube_frame_sequencer.sv
// Scoreboard bench: a frame-time reference model predicts every output cycle.
module tb_cube_frame_sequencer;

  localparam int DWELL  = 3;
  localparam int BLANK  = 1;
  localparam int PERIOD = DWELL + BLANK;
  localparam int FRAME  = 10 * PERIOD;

  logic       clk;
  logic       rst, en, wr_en, swap_req;
  logic [3:0] wr_addr;
  logic [9:0] wr_data;
  logic       swap_ack, frame_start;
  logic [9:0] x, y;

  cube_frame_sequencer #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .frame_start (frame_start),
    .x           (x),
    .y           (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [21:0] sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;

  bit          m_run;
  int          m_t;
  bit          m_bank, m_pend;
  logic [9:0]  m_buf [2][10];

  // Reference model: position within the frame is a single time index m_t.
  initial begin
    forever begin : model_step
      logic [21:0] e;
      logic        ack, fs, hit;
      int          row, off;
      @(posedge clk);
      ack = 1'b0;
      fs  = 1'b0;
      if (rst) begin
        m_run = 0; m_t = 0; m_bank = 0; m_pend = 0;
        for (int b = 0; b < 2; b++)
          for (int i = 0; i < 10; i++) m_buf[b][i] = '0;
      end else begin
        hit = m_run && en && (m_t == FRAME - 1);
        if (wr_en && wr_addr <= 4'd9) m_buf[~m_bank][wr_addr] = wr_data;
        if (hit) begin
          ack = m_pend || swap_req;
          if (ack) m_bank = ~m_bank;
          m_pend = 0;
        end else if (swap_req) begin
          m_pend = 1;
        end
        if (!en) begin
          m_run = 0; m_t = 0;
        end else if (!m_run) begin
          m_run = 1; m_t = 0; fs = 1'b1;
        end else begin
          m_t = (m_t + 1) % FRAME;
          fs  = (m_t == 0);
        end
      end
      row = m_t / PERIOD;
      off = m_t % PERIOD;
      if (m_run && off >= BLANK)
        e = {m_buf[m_bank][row], 10'(1 << (9 - row)), ack, fs};
      else
        e = {20'h0, ack, fs};
      sb_q.push_back(e);
    end
  end

  // Monitor: compares DUT outputs on the falling edge.
  initial begin
    forever begin : monitor_step
      logic [21:0] exp_v;
      @(negedge clk);
      cyc++;
      if (sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        checks++;
        if ({x, y, swap_ack, frame_start} !== exp_v) begin
          errors++;
          $display("FAIL outputs cyc=%0d got x=%h y=%h ack=%b fs=%b exp x=%h y=%h ack=%b fs=%b",
                   cyc, x, y, swap_ack, frame_start,
                   exp_v[21:12], exp_v[11:2], exp_v[1], exp_v[0]);
        end
        checks++;
        if (!((y == 10'h0) || $onehot(y))) begin
          errors++;
          $display("FAIL y_onehot cyc=%0d got y=%h exp zero or one-hot", cyc, y);
        end
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic we,
                      input logic [3:0] a, input logic [9:0] d, input logic s);
    @(negedge clk);
    rst = r; en = e; wr_en = we; wr_addr = a; wr_data = d; swap_req = s;
  endtask

  task automatic run(input int n, input logic e);
    repeat (n) step(1'b0, e, 1'b0, 4'd0, 10'd0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [9:0] d);
    step(1'b0, 1'b1, 1'b1, a, d, 1'b0);
  endtask

  // Advance until the model shows frame time t, bounded.
  task automatic wait_t(input int t);
    int k = 0;
    while (!(m_run && m_t == t) && k < 200) begin
      run(1, 1'b1);
      k++;
    end
    if (k >= 200) begin
      errors++;
      $display("FAIL wait_t timeout got t=%0d exp t=%0d", m_t, t);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
    step(1'b1, 1'b0, 1'b0, 4'd0, 10'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 10'd0, 1'b0);
    run(3, 1'b0);

    // Blank frames: y walks rows, x stays dark.
    run(85, 1'b1);

    // Row 3 pattern with a mid-frame swap request.
    wr(4'd3, 10'h2AA);
    wait_t(15);
    step(1'b0, 1'b1, 1'b0, 4'd0, 10'd0, 1'b1);
    run(90, 1'b1);

    // Three requests in one frame merge into one swap.
    wr(4'd5, 10'h0F0);
    wait_t(5);
    step(1'b0, 1'b1, 1'b0, 4'd0, 10'd0, 1'b1);
    wait_t(12);
    step(1'b0, 1'b1, 1'b0, 4'd0, 10'd0, 1'b1);
    wait_t(30);
    step(1'b0, 1'b1, 1'b0, 4'd0, 10'd0, 1'b1);
    run(90, 1'b1);

    // Out-of-range write address must not touch the buffer.
    for (int i = 0; i < 10; i++) wr(4'(i), 10'h0);
    wr(4'd12, 10'h3FF);
    step(1'b0, 1'b1, 1'b0, 4'd0, 10'd0, 1'b1);
    run(90, 1'b1);

    // Disable mid-row 5, request swap while idle, re-enable.
    wr(4'd2, 10'h111);
    wait_t(5 * PERIOD + 2);
    step(1'b0, 1'b0, 1'b0, 4'd0, 10'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 10'd0, 1'b1);
    run(3, 1'b0);
    run(90, 1'b1);

    // Reset during row 7 with front loaded.
    for (int i = 0; i < 10; i++) wr(4'(i), 10'h155);
    step(1'b0, 1'b1, 1'b0, 4'd0, 10'd0, 1'b1);
    run(45, 1'b1);
    wait_t(7 * PERIOD + 2);
    step(1'b1, 1'b1, 1'b0, 4'd0, 10'd0, 1'b0);
    run(2, 1'b0);
    run(50, 1'b1);

    // Boundary-cycle write lands in the new front frame.
    wr(4'd0, 10'h0C3);
    wait_t(FRAME - 1);
    step(1'b0, 1'b1, 1'b1, 4'd1, 10'h30C, 1'b1);
    run(45, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 999) == 0,
           $urandom_range(0, 199) != 0,
           $urandom_range(0, 3) == 0,
           4'($urandom_range(0, 15)),
           10'($urandom),
           $urandom_range(0, 59) == 0);
    end
    run(5, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
